// File: rtl/alu_cmd_issuer_if.sv
// Bundles the upstream command, MY_DESIGN issue and downstream result channels.
// The master modport is the issuer's view; slave is the surrounding environment.
interface alu_cmd_issuer_if #(parameter int DEPTH = 4);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [2:0]             cmd_op;
   logic [31:0]            cmd_a;
   logic [31:0]            cmd_b;
   logic                   alu_valid;
   logic [2:0]             alu_ctrl;
   logic [31:0]            alu_a;
   logic [31:0]            alu_b;
   logic [31:0]            alu_out;
   logic                   res_valid;
   logic                   res_ready;
   logic [2:0]             res_op;
   logic [31:0]            res_data;
   logic [$clog2(DEPTH):0] cmd_count;

   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
      output cmd_ready, alu_valid, alu_ctrl, alu_a, alu_b,
             res_valid, res_op, res_data, cmd_count
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
      input  cmd_ready, alu_valid, alu_ctrl, alu_a, alu_b,
             res_valid, res_op, res_data, cmd_count
   );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers {op, A, B} commands in a small FIFO, issues each one to MY_DESIGN and
// returns the captured {op, result} downstream.
//
// state   | meaning
// IDLE    | nothing in flight, waiting for a buffered command
// ISSUE   | alu_valid high for one cycle; MY_DESIGN latches ctrl at its end
// CAPTURE | operands still driven so the live ALU output is valid; register it
// RESP    | res_valid high, result held until downstream accepts
module alu_cmd_issuer #(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_cmd_issuer_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [2:0]    fifo_op [DEPTH];
   logic [31:0]   fifo_a  [DEPTH];
   logic [31:0]   fifo_b  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   logic [2:0]    op_r;
   logic [31:0]   a_r;
   logic [31:0]   b_r;
   logic [2:0]    res_op_r;
   logic [31:0]   res_data_r;

   assign bus.cmd_ready = (count != CW'(DEPTH));
   assign push          = bus.cmd_valid && bus.cmd_ready;

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr] <= bus.cmd_op;
         fifo_a[wr_ptr]  <= bus.cmd_a;
         fifo_b[wr_ptr]  <= bus.cmd_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE:   state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_RESP;
         S_RESP: begin
            if (bus.res_ready) begin
               if (count != '0) begin
                  pop       = 1'b1;
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand registers drive MY_DESIGN directly, so they stay put through CAPTURE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r       <= '0;
         a_r        <= '0;
         b_r        <= '0;
         res_op_r   <= '0;
         res_data_r <= '0;
      end else begin
         if (pop) begin
            op_r <= fifo_op[rd_ptr];
            a_r  <= fifo_a[rd_ptr];
            b_r  <= fifo_b[rd_ptr];
         end
         if (state == S_CAPTURE) begin
            res_op_r   <= op_r;
            res_data_r <= bus.alu_out;
         end
      end
   end

   assign bus.alu_valid = (state == S_ISSUE);
   assign bus.alu_ctrl  = op_r;
   assign bus.alu_a     = a_r;
   assign bus.alu_b     = b_r;
   assign bus.res_valid = (state == S_RESP);
   assign bus.res_op    = res_op_r;
   assign bus.res_data  = res_data_r;
   assign bus.cmd_count = count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Drives alu_cmd_issuer against a behavioural MY_DESIGN and checks every
// returned result against a queue of expected {op, result} pairs.
module tb_alu_cmd_issuer;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_cmd_issuer_if #(.DEPTH(DEPTH)) bus ();

   alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a << b[4:0];
         3'd3:    return a ^ b;
         3'd4:    return a >> b[4:0];
         3'd5:    return 32'($signed(a) >>> b[4:0]);
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // MY_DESIGN: ctrl latched on valid, output combinational from live operands.
   logic [2:0] ctrl_l;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             ctrl_l <= 3'd0;
      else if (bus.alu_valid) ctrl_l <= bus.alu_ctrl;
   end
   assign bus.alu_out = alu_ref(ctrl_l, bus.alu_a, bus.alu_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] data;
   } res_t;

   res_t        sb[$];
   logic        held_v;
   logic [2:0]  held_op;
   logic [31:0] held_data;
   logic        prev_alu_valid;

   // Inputs change just after posedge, so negedge sees what the next edge will use.
   always @(negedge clk) begin
      res_t e;
      if (!rst_n) begin
         sb.delete();
         held_v         = 1'b0;
         prev_alu_valid = 1'b0;
      end else begin
         if (bus.cmd_valid && bus.cmd_ready)
            sb.push_back('{bus.cmd_op, alu_ref(bus.cmd_op, bus.cmd_a, bus.cmd_b)});
         check("alu_valid_pulse", 32'(prev_alu_valid & bus.alu_valid), 32'd0);
         prev_alu_valid = bus.alu_valid;
         if (bus.res_valid) begin
            if (held_v) begin
               check("res_op_stable", 32'(bus.res_op), 32'(held_op));
               check("res_data_stable", bus.res_data, held_data);
            end
            if (bus.res_ready) begin
               held_v = 1'b0;
               check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("res_op", 32'(bus.res_op), 32'(e.op));
                  check("res_data", bus.res_data, e.data);
               end
            end else begin
               held_v    = 1'b1;
               held_op   = bus.res_op;
               held_data = bus.res_data;
            end
         end else begin
            held_v = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_alu_valid"}, 32'(bus.alu_valid), 32'd0);
      check({tag, "_alu_ctrl"},  32'(bus.alu_ctrl), 32'd0);
      check({tag, "_alu_a"},     bus.alu_a, 32'd0);
      check({tag, "_alu_b"},     bus.alu_b, 32'd0);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      check({tag, "_res_op"},    32'(bus.res_op), 32'd0);
      check({tag, "_res_data"},  bus.res_data, 32'd0);
      check({tag, "_cmd_count"}, 32'(bus.cmd_count), 32'd0);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic drain(input int max_cycles);
      bit done = 1'b0;
      bus.res_ready = 1'b1;
      for (int t = 0; t < max_cycles && !done; t++) begin
         tick();
         done = (sb.size() == 0) && (bus.cmd_count == 0) && !bus.res_valid;
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   task automatic wait_res(input int max_cycles, input string tag);
      for (int t = 0; t < max_cycles && !bus.res_valid; t++) tick();
      check(tag, 32'(bus.res_valid), 32'd1);
   endtask

   initial begin
      int            got;
      int            cyc [3];
      logic [31:0]   dat [3];
      int            accepted;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_a     = 32'd0;
      bus.cmd_b     = 32'd0;
      bus.res_ready = 1'b0;

      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         check("idle_alu_valid", 32'(bus.alu_valid), 32'd0);
         check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      end

      // Single sub with exact latency
      push(3'd1, 32'd5, 32'd7);
      check("sub_pre_issue", 32'(bus.alu_valid), 32'd0);
      tick();
      check("sub_issue_valid", 32'(bus.alu_valid), 32'd1);
      check("sub_issue_ctrl", 32'(bus.alu_ctrl), 32'd1);
      tick();
      check("sub_cap_valid", 32'(bus.alu_valid), 32'd0);
      check("sub_cap_a", bus.alu_a, 32'd5);
      check("sub_cap_res_valid", 32'(bus.res_valid), 32'd0);
      tick();
      check("sub_res_valid", 32'(bus.res_valid), 32'd1);
      check("sub_res_op", 32'(bus.res_op), 32'd1);
      check("sub_res_data", bus.res_data, 32'hFFFF_FFFE);
      bus.res_ready = 1'b1;
      tick();
      check("sub_after_hs", 32'(bus.res_valid), 32'd0);

      // Back-to-back with res_ready held high
      push(3'd5, 32'h8000_0000, 32'd4);
      push(3'd2, 32'd1, 32'd31);
      push(3'd7, 32'h0000_F0F0, 32'h0000_FF00);
      got = 0;
      for (int t = 0; t < 30 && got < 3; t++) begin
         if (bus.res_valid) begin
            cyc[got] = t;
            dat[got] = bus.res_data;
            got++;
         end
         tick();
      end
      check("b2b_count", 32'(got), 32'd3);
      if (got == 3) begin
         check("b2b_sra", dat[0], 32'hF800_0000);
         check("b2b_sll", dat[1], 32'h8000_0000);
         check("b2b_and", dat[2], 32'h0000_F000);
         check("b2b_gap1", 32'(cyc[1] - cyc[0]), 32'd3);
         check("b2b_gap2", 32'(cyc[2] - cyc[1]), 32'd3);
      end
      drain(50);

      // Backpressure: 1 in flight + DEPTH buffered
      bus.res_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 3'($urandom_range(0, 7));
         bus.cmd_a     = $urandom;
         bus.cmd_b     = $urandom;
         if (bus.cmd_ready) accepted++;
         tick();
      end
      bus.cmd_valid = 1'b0;
      check("bp_accepted", 32'(accepted), 32'd5);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_cmd_count", 32'(bus.cmd_count), 32'd4);
      repeat (5) tick();
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      drain(100);

      // Simultaneous push and pop at count 2
      bus.res_ready = 1'b0;
      push(3'd0, $urandom, $urandom);
      push(3'd3, $urandom, $urandom);
      push(3'd6, $urandom, $urandom);
      check("pp_pre_count", 32'(bus.cmd_count), 32'd2);
      wait_res(10, "pp_wait_res");
      bus.res_ready = 1'b1;
      push(3'd4, $urandom, $urandom);
      bus.res_ready = 1'b0;
      check("pp_post_count", 32'(bus.cmd_count), 32'd2);
      drain(100);

      // Reset during CAPTURE with 3 queued
      bus.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(3'($urandom_range(0, 7)), $urandom, $urandom);
      wait_res(10, "rm_wait_res");
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check("rm_issue", 32'(bus.alu_valid), 32'd1);
      tick();
      check("rm_capture_count", 32'(bus.cmd_count), 32'd3);
      rst_n = 1'b0;
      #1;
      check_reset("rm");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.res_ready = 1'b1;
      repeat (12) begin
         tick();
         check("rm_no_res", 32'(bus.res_valid), 32'd0);
         check("rm_no_issue", 32'(bus.alu_valid), 32'd0);
      end

      // Randomized traffic against the scoreboard
      for (int t = 0; t < 400; t++) begin
         bus.cmd_valid = ($urandom_range(0, 99) < 60);
         bus.cmd_op    = 3'($urandom_range(0, 7));
         bus.cmd_a     = $urandom;
         bus.cmd_b     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         bus.res_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      bus.cmd_valid = 1'b0;
      drain(200);
      check("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
